// File: rtl/mbist_addr_seq_if.sv
// Command/config/address bundle between the MBIST march controller (master)
// and the 2-D address sequencer (slave). Optional BIST_ADDR_CMPL_EN adds addr_cmpl_en.
interface mbist_addr_seq_if #(
  parameter int pROW_BITS = 3,
  parameter int pCOL_BITS = 2
);
  localparam int pADDR_WIDTH = pROW_BITS + pCOL_BITS;

  // Commands are single-cycle strobes with no ready: the sequencer accepts
  // whatever is asserted at every rising bist_clk, highest priority wins.
  logic [pROW_BITS-1:0]   cfg_row_max;
  logic [pCOL_BITS-1:0]   cfg_col_max;
  logic                   cfg_fast_row;
  logic                   addr_clr_en;
  logic                   addr_ld_max_en;
  logic                   addr_up_en;
  logic                   addr_dn_en;
`ifdef BIST_ADDR_CMPL_EN
  logic                   addr_cmpl_en;
`endif
  logic [pADDR_WIDTH-1:0] bist_addr;
  logic                   max_addr_done;
  logic                   min_addr_done;
  logic                   addr_wrap;

  modport master (
`ifdef BIST_ADDR_CMPL_EN
    output addr_cmpl_en,
`endif
    output cfg_row_max, cfg_col_max, cfg_fast_row,
    output addr_clr_en, addr_ld_max_en, addr_up_en, addr_dn_en,
    input  bist_addr, max_addr_done, min_addr_done, addr_wrap
  );

  modport slave (
`ifdef BIST_ADDR_CMPL_EN
    input  addr_cmpl_en,
`endif
    input  cfg_row_max, cfg_col_max, cfg_fast_row,
    input  addr_clr_en, addr_ld_max_en, addr_up_en, addr_dn_en,
    output bist_addr, max_addr_done, min_addr_done, addr_wrap
  );
endinterface

// File: rtl/mbist_addr_seq.sv
// 2-D MBIST address sequencer: row/col counter with programmable limits, fast-row or
// fast-column order, up/down wrap, and a registered address. BIST_ADDR_CMPL_EN adds complement output.
module mbist_addr_seq #(
  parameter  int pROW_BITS   = 3,
  parameter  int pCOL_BITS   = 2,
  localparam int pADDR_WIDTH = pROW_BITS + pCOL_BITS
) (
  input  logic              bist_clk,
  input  logic              bist_rst_n,
  mbist_addr_seq_if.slave   bus
);

  logic [pROW_BITS-1:0]   row_cnt, row_max, row_nx;
  logic [pCOL_BITS-1:0]   col_cnt, col_max, col_nx;
  logic                   fast_row;
  logic                   wrap_nx, wrap_q;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic                   addr_wrap_q;
  logic                   any_cmd;

  assign any_cmd = bus.addr_clr_en | bus.addr_ld_max_en | bus.addr_up_en | bus.addr_dn_en;

  // Next counter value; the inner field is col in fast-column order, row in fast-row order.
  always_comb begin
    row_nx  = row_cnt;
    col_nx  = col_cnt;
    wrap_nx = 1'b0;
    if (bus.addr_clr_en) begin
      row_nx = '0;
      col_nx = '0;
    end else if (bus.addr_ld_max_en) begin
      row_nx = row_max;
      col_nx = col_max;
    end else if (bus.addr_up_en) begin
      if (!fast_row) begin
        if (col_cnt < col_max) begin
          col_nx = col_cnt + pCOL_BITS'(1);
        end else begin
          col_nx = '0;
          if (row_cnt < row_max) row_nx = row_cnt + pROW_BITS'(1);
          else begin
            row_nx  = '0;
            wrap_nx = 1'b1;
          end
        end
      end else begin
        if (row_cnt < row_max) begin
          row_nx = row_cnt + pROW_BITS'(1);
        end else begin
          row_nx = '0;
          if (col_cnt < col_max) col_nx = col_cnt + pCOL_BITS'(1);
          else begin
            col_nx  = '0;
            wrap_nx = 1'b1;
          end
        end
      end
    end else if (bus.addr_dn_en) begin
      if (!fast_row) begin
        if (col_cnt > '0) begin
          col_nx = col_cnt - pCOL_BITS'(1);
        end else begin
          col_nx = col_max;
          if (row_cnt > '0) row_nx = row_cnt - pROW_BITS'(1);
          else begin
            row_nx  = row_max;
            wrap_nx = 1'b1;
          end
        end
      end else begin
        if (row_cnt > '0) begin
          row_nx = row_cnt - pROW_BITS'(1);
        end else begin
          row_nx = row_max;
          if (col_cnt > '0) col_nx = col_cnt - pCOL_BITS'(1);
          else begin
            col_nx  = col_max;
            wrap_nx = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      row_cnt  <= '0;
      col_cnt  <= '0;
      row_max  <= '1;
      col_max  <= '1;
      fast_row <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      row_cnt <= row_nx;
      col_cnt <= col_nx;
      wrap_q  <= wrap_nx;
      if (bus.addr_clr_en) begin
        row_max  <= bus.cfg_row_max;
        col_max  <= bus.cfg_col_max;
        fast_row <= bus.cfg_fast_row;
      end
    end
  end

`ifdef BIST_ADDR_CMPL_EN
  // Complement select is captured with the command so it travels with the counter value.
  logic cmpl_q;

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n)  cmpl_q <= 1'b0;
    else if (any_cmd) cmpl_q <= bus.addr_cmpl_en;
  end

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      addr_q      <= '0;
      addr_wrap_q <= 1'b0;
    end else begin
      addr_q      <= cmpl_q ? {row_max - row_cnt, col_max - col_cnt} : {row_cnt, col_cnt};
      addr_wrap_q <= wrap_q;
    end
  end
`else
  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      addr_q      <= '0;
      addr_wrap_q <= 1'b0;
    end else begin
      addr_q      <= {row_cnt, col_cnt};
      addr_wrap_q <= wrap_q;
    end
  end

  logic unused_any_cmd;
  assign unused_any_cmd = any_cmd;
`endif

  assign bus.bist_addr     = addr_q;
  assign bus.addr_wrap     = addr_wrap_q;
  assign bus.max_addr_done = (row_cnt == row_max) && (col_cnt == col_max);
  assign bus.min_addr_done = (row_cnt == '0) && (col_cnt == '0);

endmodule

// File: tb/tb_mbist_addr_seq.sv
// Scoreboard bench for mbist_addr_seq: a linear-index model predicts each cycle's
// counter, pushes {wrap,addr} and pops it one cycle later against bist_addr/addr_wrap.
module tb_mbist_addr_seq;
  localparam int RB = 3;
  localparam int CB = 2;
  localparam int W  = RB + CB;
  localparam int EW = W + 1;

  logic bist_clk;
  logic bist_rst_n;

  mbist_addr_seq_if #(.pROW_BITS(RB), .pCOL_BITS(CB)) bus ();

  mbist_addr_seq #(.pROW_BITS(RB), .pCOL_BITS(CB)) dut (
    .bist_clk   (bist_clk),
    .bist_rst_n (bist_rst_n),
    .bus        (bus)
  );

  // clock / reset
  initial bist_clk = 1'b0;
  always #5 bist_clk = ~bist_clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [EW-1:0] exp_q[$];

  // model state
  int mr, mc, m_rmax, m_cmax;
  logic m_fr, m_cmpl, cmpl_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; m_rmax = 7; m_cmax = 3; m_fr = 1'b0; m_cmpl = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_step(input logic up, output logic wrap);
    int nr, nc, tot, idx;
    nr  = m_rmax + 1;
    nc  = m_cmax + 1;
    tot = nr * nc;
    idx = m_fr ? (mc * nr + mr) : (mr * nc + mc);
    if (up) begin
      wrap = (idx == tot - 1);
      idx  = wrap ? 0 : idx + 1;
    end else begin
      wrap = (idx == 0);
      idx  = wrap ? tot - 1 : idx - 1;
    end
    if (m_fr) begin mc = idx / nr; mr = idx % nr; end
    else      begin mr = idx / nc; mc = idx % nc; end
  endtask

  task automatic set_cfg(input int r, input int c, input logic fr);
    bus.cfg_row_max  = RB'(r);
    bus.cfg_col_max  = CB'(c);
    bus.cfg_fast_row = fr;
  endtask

  // driver: one clock cycle with the given command strobes
  task automatic cycle(input logic clr, input logic ld, input logic up, input logic dn);
    logic wrap;
    int ar, ac;
    logic [EW-1:0] e;
    bus.addr_clr_en    = clr;
    bus.addr_ld_max_en = ld;
    bus.addr_up_en     = up;
    bus.addr_dn_en     = dn;
`ifdef BIST_ADDR_CMPL_EN
    bus.addr_cmpl_en   = cmpl_in;
`endif
    @(posedge bist_clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("q_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("addr", 32'(bus.bist_addr), 32'(e[W-1:0]));
      chk("wrap", 32'(bus.addr_wrap), 32'(e[W]));
    end
    wrap = 1'b0;
    if (clr) begin
      mr = 0; mc = 0;
      m_rmax = int'(bus.cfg_row_max);
      m_cmax = int'(bus.cfg_col_max);
      m_fr   = bus.cfg_fast_row;
    end else if (ld) begin
      mr = m_rmax; mc = m_cmax;
    end else if (up || dn) begin
      model_step(up, wrap);
    end
    if (clr || ld || up || dn) m_cmpl = cmpl_in;
    chk("max_done", 32'(bus.max_addr_done), 32'((mr == m_rmax) && (mc == m_cmax)));
    chk("min_done", 32'(bus.min_addr_done), 32'((mr == 0) && (mc == 0)));
    ar = m_cmpl ? m_rmax - mr : mr;
    ac = m_cmpl ? m_cmax - mc : mc;
    e  = {wrap, RB'(ar), CB'(ac)};
    exp_q.push_back(e);
    bus.addr_clr_en = 1'b0; bus.addr_ld_max_en = 1'b0;
    bus.addr_up_en  = 1'b0; bus.addr_dn_en     = 1'b0;
  endtask

  initial begin
    bist_rst_n = 1'b0;
    cmpl_in = 1'b0;
    set_cfg(0, 0, 1'b0);
    bus.addr_clr_en = 1'b0; bus.addr_ld_max_en = 1'b0;
    bus.addr_up_en  = 1'b0; bus.addr_dn_en     = 1'b0;
`ifdef BIST_ADDR_CMPL_EN
    bus.addr_cmpl_en = 1'b0;
`endif
    repeat (2) @(posedge bist_clk);
    #1;
    chk("rst_addr", 32'(bus.bist_addr), 32'd0);
    chk("rst_wrap", 32'(bus.addr_wrap), 32'd0);
    chk("rst_max",  32'(bus.max_addr_done), 32'd0);
    chk("rst_min",  32'(bus.min_addr_done), 32'd1);
    @(negedge bist_clk);
    bist_rst_n = 1'b1;
    model_reset();

    // full array, fast-column, 32 ups: 0..31 then wrap to 0
    set_cfg(7, 3, 1'b0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 32; i++) cycle(0, 0, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // 3x2 sub-array, fast-row
    set_cfg(2, 1, 1'b1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0);

    // load max then step down; down from 0 wraps to 31
    set_cfg(7, 3, 1'b0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0);

    // command priority
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(0, 1, 0, 1);
    repeat (2) cycle(0, 0, 0, 0);

    // reset lands while a wrap pulse is in flight
    cycle(0, 0, 1, 0);
    bist_rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.bist_addr), 32'd0);
    chk("arst_wrap", 32'(bus.addr_wrap), 32'd0);
    chk("arst_min",  32'(bus.min_addr_done), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge bist_clk);
      #1;
      chk("arst_wrap_hold", 32'(bus.addr_wrap), 32'd0);
    end
    @(negedge bist_clk);
    bist_rst_n = 1'b1;
    model_reset();
    repeat (2) cycle(0, 0, 0, 0);

    // degenerate limits: both zero wraps on every step
    set_cfg(0, 0, 1'b0);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);

`ifdef BIST_ADDR_CMPL_EN
    set_cfg(7, 3, 1'b0);
    cmpl_in = 1'b1;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 33; i++) cycle(0, 0, 1, 0);
    cmpl_in = 1'b0;
    cycle(0, 0, 0, 0);
`endif

    // random commands, random limits latched on clears
    for (int i = 0; i < 400; i++) begin
      logic c, l, u, d;
      set_cfg($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
`ifdef BIST_ADDR_CMPL_EN
      cmpl_in = 1'($urandom_range(0, 1));
`endif
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 19) == 0);
      u = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 2) != 0);
      cycle(c, l, u, d);
    end
    cycle(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
